// File: rtl/ktane_bus_pkg.sv
// Shared definitions for the KTANE peripheral bus: region map, read-mux
// encodings and the arbiter FSM states.
package ktane_bus_pkg;

    // Region identifiers; the value doubles as the region_en bit index
    typedef enum logic [2:0] {
        REG_RAM    = 3'd0,
        REG_BUTTON = 3'd1,
        REG_KEYPAD = 3'd2,
        REG_MORSE  = 3'd3,
        REG_WIRES  = 3'd4,
        REG_EXTRAS = 3'd5
    } region_e;

    localparam int EN_RAM    = 0;
    localparam int EN_BUTTON = 1;
    localparam int EN_KEYPAD = 2;
    localparam int EN_MORSE  = 3;
    localparam int EN_WIRES  = 4;
    localparam int EN_EXTRAS = 5;

    // Read-mux select; morse has no read path and parks on ram
    localparam logic [2:0] SEL_RAM    = 3'd0;
    localparam logic [2:0] SEL_BUTTON = 3'd1;
    localparam logic [2:0] SEL_KEYPAD = 3'd2;
    localparam logic [2:0] SEL_WIRES  = 3'd3;
    localparam logic [2:0] SEL_EXTRAS = 3'd4;

    // Inclusive region bounds; 0xFFFC-0xFFFF is left unmapped
    localparam logic [15:0] RAM_BASE    = 16'h0000;
    localparam logic [15:0] RAM_LIMIT   = 16'hBFFF;
    localparam logic [15:0] BTN_BASE    = 16'hC000;
    localparam logic [15:0] BTN_LIMIT   = 16'hCCCB;
    localparam logic [15:0] KEY_BASE    = 16'hCCCC;
    localparam logic [15:0] KEY_LIMIT   = 16'hD997;
    localparam logic [15:0] MORSE_BASE  = 16'hD998;
    localparam logic [15:0] MORSE_LIMIT = 16'hE663;
    localparam logic [15:0] WIRES_BASE  = 16'hE664;
    localparam logic [15:0] WIRES_LIMIT = 16'hF32F;
    localparam logic [15:0] EXTRA_BASE  = 16'hF330;
    localparam logic [15:0] EXTRA_LIMIT = 16'hFFFB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

endpackage

// File: rtl/ktane_addr_decode.sv
// Combinational address decode: address -> one-hot region enable,
// read-mux select and unmapped flag. Shared by all bus masters.
module ktane_addr_decode
    import ktane_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [5:0]            region_en,
    output logic [2:0]            bus_sel,
    output logic                  unmapped
);

    region_e rg;

    // Range match, then map the region to its enable bit and mux select
    always_comb begin
        rg        = REG_RAM;
        unmapped  = 1'b0;
        region_en = '0;
        bus_sel   = SEL_RAM;
        if (addr <= ADDR_WIDTH'(RAM_LIMIT))
            rg = REG_RAM;
        else if (addr >= ADDR_WIDTH'(BTN_BASE) && addr <= ADDR_WIDTH'(BTN_LIMIT))
            rg = REG_BUTTON;
        else if (addr >= ADDR_WIDTH'(KEY_BASE) && addr <= ADDR_WIDTH'(KEY_LIMIT))
            rg = REG_KEYPAD;
        else if (addr >= ADDR_WIDTH'(MORSE_BASE) && addr <= ADDR_WIDTH'(MORSE_LIMIT))
            rg = REG_MORSE;
        else if (addr >= ADDR_WIDTH'(WIRES_BASE) && addr <= ADDR_WIDTH'(WIRES_LIMIT))
            rg = REG_WIRES;
        else if (addr >= ADDR_WIDTH'(EXTRA_BASE) && addr <= ADDR_WIDTH'(EXTRA_LIMIT))
            rg = REG_EXTRAS;
        else
            unmapped = 1'b1;

        if (!unmapped) begin
            case (rg)
                REG_RAM:    begin region_en[EN_RAM]    = 1'b1; bus_sel = SEL_RAM;    end
                REG_BUTTON: begin region_en[EN_BUTTON] = 1'b1; bus_sel = SEL_BUTTON; end
                REG_KEYPAD: begin region_en[EN_KEYPAD] = 1'b1; bus_sel = SEL_KEYPAD; end
                REG_MORSE:  begin region_en[EN_MORSE]  = 1'b1; bus_sel = SEL_RAM;    end
                REG_WIRES:  begin region_en[EN_WIRES]  = 1'b1; bus_sel = SEL_WIRES;  end
                REG_EXTRAS: begin region_en[EN_EXTRAS] = 1'b1; bus_sel = SEL_EXTRAS; end
                default:    begin region_en = '0;              bus_sel = SEL_RAM;    end
            endcase
        end
    end

endmodule

// File: rtl/ktane_bus_arb.sv
// Two-master round-robin arbiter and access sequencer for the KTANE bus.
// Each access runs IDLE -> ISSUE -> WAIT (RD_LATENCY cycles) -> ACK.
// Optional macro KTANE_BUS_ERR_CNT_EN builds a saturating unmapped-access
// counter on err_count; without it err_count is tied to 0.
module ktane_bus_arb
    import ktane_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m0_gnt,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,
    output logic                  m1_gnt,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic                  bus_we,
    output logic [5:0]            region_en,
    output logic [2:0]            bus_sel,
    input  logic [DATA_WIDTH-1:0] bus_q,
    output logic [7:0]            err_count
);

    state_e state, state_d;
    logic [3:0] wcnt, wcnt_d;
    logic       own, own_d;          // master owning the current access
    logic       ptr_last, ptr_d;     // last master served (1 = m1)
    logic       lat_we, lat_we_d;
    logic       lat_unm, lat_unm_d;
    logic       lat_morse, lat_morse_d;
    logic [1:0] gnt_q, gnt_d, ack_q, ack_d, err_q, err_d;
    logic [1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_data_d;
    logic                  bus_we_d;
    logic [5:0]            region_en_d;
    logic [2:0]            bus_sel_d;

    // Round-robin winner: m1 takes a tie only when m0 was served last
    logic                  win;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  win_we;
    logic [5:0]            dec_en;
    logic [2:0]            dec_sel;
    logic                  dec_unm;

    assign win       = m1_req & (~m0_req | ~ptr_last);
    assign win_addr  = win ? m1_addr  : m0_addr;
    assign win_wdata = win ? m1_wdata : m0_wdata;
    assign win_we    = win ? m1_we    : m0_we;

    ktane_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_dec (
        .addr      (win_addr),
        .region_en (dec_en),
        .bus_sel   (dec_sel),
        .unmapped  (dec_unm)
    );

    // Next-state and next-output logic; pulse-type outputs default to 0
    always_comb begin
        state_d     = state;
        wcnt_d      = wcnt;
        own_d       = own;
        ptr_d       = ptr_last;
        lat_we_d    = lat_we;
        lat_unm_d   = lat_unm;
        lat_morse_d = lat_morse;
        gnt_d       = gnt_q;
        ack_d       = '0;
        err_d       = '0;
        rdata_d     = '0;
        bus_addr_d  = '0;
        bus_data_d  = '0;
        bus_we_d    = 1'b0;
        region_en_d = '0;
        bus_sel_d   = bus_sel;
        case (state)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    own_d       = win;
                    gnt_d       = win ? 2'b10 : 2'b01;
                    bus_addr_d  = win_addr;
                    bus_data_d  = win_wdata;
                    bus_we_d    = win_we;
                    region_en_d = dec_en;
                    bus_sel_d   = dec_sel;
                    lat_we_d    = win_we;
                    lat_unm_d   = dec_unm;
                    lat_morse_d = dec_en[EN_MORSE];
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wcnt_d  = 4'(RD_LATENCY - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt == 4'd0) begin
                    ack_d[own] = 1'b1;
                    err_d[own] = lat_unm;
                    if (!lat_we && !lat_unm && !lat_morse)
                        rdata_d[own] = bus_q;
                    state_d = ST_ACK;
                end else begin
                    wcnt_d = wcnt - 4'd1;
                end
            end
            ST_ACK: begin
                ptr_d     = own;
                gnt_d     = '0;
                bus_sel_d = SEL_RAM;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wcnt      <= '0;
            own       <= 1'b0;
            ptr_last  <= 1'b1;
            lat_we    <= 1'b0;
            lat_unm   <= 1'b0;
            lat_morse <= 1'b0;
            gnt_q     <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
            bus_addr  <= '0;
            bus_data  <= '0;
            bus_we    <= 1'b0;
            region_en <= '0;
            bus_sel   <= SEL_RAM;
        end else begin
            state     <= state_d;
            wcnt      <= wcnt_d;
            own       <= own_d;
            ptr_last  <= ptr_d;
            lat_we    <= lat_we_d;
            lat_unm   <= lat_unm_d;
            lat_morse <= lat_morse_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            bus_addr  <= bus_addr_d;
            bus_data  <= bus_data_d;
            bus_we    <= bus_we_d;
            region_en <= region_en_d;
            bus_sel   <= bus_sel_d;
        end
    end

    assign m0_gnt   = gnt_q[0];
    assign m1_gnt   = gnt_q[1];
    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
    assign m0_rdata = rdata_q[0];
    assign m1_rdata = rdata_q[1];

`ifdef KTANE_BUS_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of unmapped accesses, bumped in each erroring ACK
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt_q <= '0;
        else if (state == ST_ACK && lat_unm && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: doc/ktane_bus_arb.md
# ktane_bus_arb

Two-master arbiter and sequencer for the KTANE peripheral bus. It lets the game CPU (master 0) and the I2C/debug poll engine (master 1) share the memory-mapped region space: RAM, button, keypad, morse, wires and extras. It decodes the granted address into a single one-hot region enable and a read-mux select, holds the bus for a fixed access window, and returns read data with a completion pulse. It sits between the masters and the existing region blocks and replaces their free-running enable decode.

## Interface
Parameters:
- DATA_WIDTH, 16, bus data width
- ADDR_WIDTH, 16, bus address width
- RD_LATENCY, 2, cycles from the region-enable cycle to valid bus_q; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- m0_req / m1_req  in  1  access request; held until the matching ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_WIDTH  access address
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data
- m0_gnt / m1_gnt  out  1  master currently owns the bus
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  DATA_WIDTH  read data, valid while ack is high
- m0_err / m1_err  out  1  with ack: the access hit an unmapped address
- bus_addr  out  ADDR_WIDTH  address to the regions
- bus_data  out  DATA_WIDTH  write data to the regions
- bus_we  out  1  write strobe, qualified by the region enable
- region_en  out  6  one-hot enables: bit0 ram, 1 button, 2 keypad, 3 morse, 4 wires, 5 extras
- bus_sel  out  3  read-mux select: 0 ram, 1 button, 2 keypad, 3 wires, 4 extras
- bus_q  in  DATA_WIDTH  muxed read data from the regions
- err_count  out  8  count of unmapped accesses (see Configuration)

## Operation
- Address map (inclusive ranges):
  - ram 0x0000–0xBFFF
  - button 0xC000–0xCCCB
  - keypad 0xCCCC–0xD997
  - morse 0xD998–0xE663
  - wires 0xE664–0xF32F
  - extras 0xF330–0xFFFB
  - 0xFFFC–0xFFFF unmapped
- State machine: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any req is high, arbitrate, latch the winner's addr/we/wdata, assert its gnt, and go to ISSUE. Otherwise stay in IDLE.
- Arbitration: round-robin on a last-served pointer, reset to "m1 last" so m0 wins the first tie. A lone requester always wins.
- ISSUE (exactly 1 cycle):
  - Drive bus_addr, bus_data and bus_we.
  - Assert the decoded region_en bit. Hold bus_sel from ISSUE through ACK.
  - Unmapped address: no region_en bit is asserted.
- WAIT: lasts RD_LATENCY cycles. On the last WAIT edge, capture bus_q into the rdata register.
- ACK (1 cycle):
  - Pulse the winner's ack. The loser's ack, rdata and err stay 0.
  - rdata is the captured bus_q for mapped reads; 0 for writes, morse reads and unmapped accesses.
  - err = 1 only for unmapped addresses.
  - Update the pointer, drop gnt, and go to IDLE.
- Writes take the same path and latency as reads.
- A req that drops before its ack is a protocol violation. The access still completes and the ack still pulses.
- A req from the loser that arrives while the bus is busy is served at the next IDLE, ahead of a re-request from the current owner.

## Timing
- Reset values: state IDLE; every gnt, ack, err and rdata = 0; region_en = 0; bus_we = 0; bus_addr = 0; bus_data = 0; bus_sel = 0; err_count = 0; pointer = m1.
- Asserting rst mid-access aborts it immediately. No ack is produced and region_en drops asynchronously.
- Latency, with req high at edge k:
  - gnt rises at edge k+1 (ISSUE).
  - ACK falls in cycle k+2+RD_LATENCY.
  - Default RD_LATENCY = 2: req seen cycle 0, ISSUE cycle 1, WAIT cycles 2–3, ACK cycle 4.
- Throughput: IDLE lasts at least one cycle between accesses, so each access costs RD_LATENCY+3 cycles.
- Simultaneous requests in IDLE: exactly one gnt. Each gnt and region_en pattern is never more than one-hot.
- All outputs are registered.

## Configuration
- KTANE_BUS_ERR_CNT_EN defined: err_count is an 8-bit counter.
  - Increments on each ACK cycle with err = 1.
  - Saturates at 255 and clears only on rst.
- Not defined: err_count is tied to 0 and no counter logic is built. The err pulses still operate.

## Structure
- Package ktane_bus_pkg holds:
  - region enum and one-hot bit indices
  - bus_sel encodings
  - the six region base/limit constants
  - the FSM state enum
- Sub-module ktane_addr_decode: combinational address in → region_en one-hot, bus_sel and unmapped flag out. It is shared with future bus masters.

## Test plan
- m0 reads 0x0010 alone, bus_q = 0x1234 in cycle 3 → region_en = 6'b000001 in cycle 1; m0_ack and m0_rdata = 0x1234 in cycle 4; m1 outputs stay 0.
- m0 and m1 both request reads to 0xC000 at cycle 0 and hold → m0 served first (ack cycle 4). m1 gnt at cycle 6 with region_en bit1, ack cycle 9. A repeat of the same tie then goes to m0.
- m1 writes 0xF330 with data 0x00AA → region_en bit5, bus_we = 1 and bus_data = 0x00AA during ISSUE only; m1_ack with rdata 0 and err 0.
- m0 reads 0xFFFE → region_en stays 0; m0_ack with m0_err = 1 and rdata 0. With KTANE_BUS_ERR_CNT_EN, 300 such reads give err_count = 255.
- m0 reads 0xD998 (morse) → region_en bit3; rdata 0 regardless of bus_q; err 0.
- rst asserted during WAIT → outputs clear the same cycle, no ack. After release, a held req restarts from ISSUE.
